data_sram_resp: RTL and testbench

- Responder end of the data SRAM interface driven by the execute stage: accepts en/we/addr/wdata requests, performs byte-masked writes and pipelined reads.
- Returns read data after a fixed, parameterised latency, with a valid strobe, to the memory stage.
- Serves as the on-chip data memory model for the pipeline CPU and its testbenches.

---
 rtl/data_sram_resp.sv | 127 ++++++++++++
 tb/tb_data_sram_resp.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-masked writes, LATENCY-stage read pipeline, sticky addr_err.
// Defining DSRAM_STAT_EN adds the rd_cnt/wr_cnt access counters.
module data_sram_resp #(
  parameter int          ADDR_W    = 10,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        addr_err
`ifdef DSRAM_STAT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  // Handshake: every en=1 cycle is accepted (no ready); a read answers with a
  // single-cycle rvalid pulse LATENCY cycles later, and the sink cannot stall it.

  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] WINDOW = 32'd4 << ADDR_W;

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("data_sram_resp: LATENCY must be in 1..4");
    end
  endgenerate

  logic [31:0]       mem [DEPTH];
  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              is_rd;
  logic              is_wr;
  logic [31:0]       rd_word;
  logic              unused_lsb;

  always_comb begin
    offset   = data_sram_addr - BASE_ADDR;
    in_range = offset < WINDOW;
    word_idx = offset[ADDR_W+1:2];
    is_rd    = data_sram_en && (data_sram_we == 4'b0000);
    is_wr    = data_sram_en && (data_sram_we != 4'b0000);
    rd_word  = in_range ? mem[word_idx] : 32'h0;
  end

  // Byte address bits are dropped: all accesses are word-aligned.
  assign unused_lsb = ^offset[1:0];

  // Array is deliberately left out of reset so contents survive resetn.
  always_ff @(posedge clk) begin
    if (is_wr && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_we[b]) mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  logic [LATENCY-1:0] pv_q;
  logic [LATENCY-1:0] pv_d;
  logic [31:0]        pd_q [LATENCY];
  logic [31:0]        pd_d [LATENCY];
  logic               addr_err_q;
  logic               addr_err_d;

  always_comb begin
    pv_d    = '0;
    pv_d[0] = is_rd;
    pd_d[0] = rd_word;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    // Output stage keeps its last response while no read arrives.
    if (!pv_d[LATENCY-1]) pd_d[LATENCY-1] = pd_q[LATENCY-1];
    addr_err_d = addr_err_q || (data_sram_en && !in_range);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv_q       <= '0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= 32'h0;
    end else begin
      pv_q       <= pv_d;
      addr_err_q <= addr_err_d;
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= pd_d[i];
    end
  end

  assign data_sram_rdata  = pd_q[LATENCY-1];
  assign data_sram_rvalid = pv_q[LATENCY-1];
  assign addr_err         = addr_err_q;

`ifdef DSRAM_STAT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] rd_cnt_d;
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'b0, is_rd && in_range};
    wr_cnt_d = wr_cnt_q + {31'b0, is_wr && in_range};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (LATENCY 1, 3, 4) share one stimulus stream
// and are checked against a word-array plus response-queue reference model.
module tb_data_sram_resp;

  localparam int          NL   = 3;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_w  [NL];
  logic        rvalid_w [NL];
  logic        err_w    [NL];
`ifdef DSRAM_STAT_EN
  logic [31:0] rd_cnt_w [NL];
  logic [31:0] wr_cnt_w [NL];
`endif

  for (genvar g = 0; g < NL; g++) begin : g_dut
    data_sram_resp #(
      .ADDR_W   (10),
      .LATENCY  (lat_of(g)),
      .BASE_ADDR(BASE)
    ) u_dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (en),
      .data_sram_we    (we),
      .data_sram_addr  (addr),
      .data_sram_wdata (wdata),
      .data_sram_rdata (rdata_w[g]),
      .data_sram_rvalid(rvalid_w[g]),
      .addr_err        (err_w[g])
`ifdef DSRAM_STAT_EN
      ,
      .rd_cnt          (rd_cnt_w[g]),
      .wr_cnt          (wr_cnt_w[g])
`endif
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: memory by word index, per-instance response queues keyed by due edge
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q   [NL][$];
  int          due_q   [NL][$];
  logic [31:0] exp_rdata  [NL];
  logic        exp_rvalid [NL];
  logic        exp_err;
  int          exp_rd_n;
  int          exp_wr_n;
  int          edge_n;

  initial begin
    edge_n = 0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        for (int d = 0; d < NL; d++) begin
          exp_q[d].delete();
          due_q[d].delete();
          exp_rdata[d]  = 32'h0;
          exp_rvalid[d] = 1'b0;
        end
        exp_err  = 1'b0;
        exp_rd_n = 0;
        exp_wr_n = 0;
      end else begin
        logic [31:0] off;
        logic [31:0] word;
        logic        inr;
        edge_n++;
        off = addr - BASE;
        inr = off < 32'd4096;
        if (en) begin
          if (!inr) exp_err = 1'b1;
          if (we == 4'b0) begin
            word = inr ? ref_mem[int'(off >> 2)] : 32'h0;
            if (inr) exp_rd_n++;
            for (int d = 0; d < NL; d++) begin
              exp_q[d].push_back(word);
              due_q[d].push_back(edge_n + lat_of(d) - 1);
            end
          end else if (inr) begin
            word = ref_mem.exists(int'(off >> 2)) ? ref_mem[int'(off >> 2)] : 32'hx;
            for (int b = 0; b < 4; b++) if (we[b]) word[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[int'(off >> 2)] = word;
            exp_wr_n++;
          end
        end
        for (int d = 0; d < NL; d++) begin
          if (due_q[d].size() > 0 && due_q[d][0] == edge_n) begin
            exp_rvalid[d] = 1'b1;
            exp_rdata[d]  = exp_q[d].pop_front();
            void'(due_q[d].pop_front());
          end else begin
            exp_rvalid[d] = 1'b0;
          end
        end
      end
    end
  end

  // driver: present one request for one cycle, return #1 after the sampling edge
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] dat);
    en = e; we = w; addr = a; wdata = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NL; d++) begin
      checks++;
      if (rvalid_w[d] !== 1'b0 || rdata_w[d] !== 32'h0 || err_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset lat%0d: rvalid=%b rdata=%h err=%b, want 0/0/0",
                 lat_of(d), rvalid_w[d], rdata_w[d], err_w[d]);
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'hF, BASE + 32'(i * 4), $urandom);
      for (int d = 0; d < NL; d++) begin
        checks++;
        if (rvalid_w[d] !== exp_rvalid[d] || err_w[d] !== exp_err) begin
          errors++;
          $display("FAIL init lat%0d: rvalid=%b err=%b, want %b/%b",
                   lat_of(d), rvalid_w[d], err_w[d], exp_rvalid[d], exp_err);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int seen [NL];
    for (int d = 0; d < NL; d++) seen[d] = 0;
    drive(1'b1, 4'hF, 32'h1C00_0010, 32'hDEAD_BEEF);
    drive(1'b1, 4'h0, 32'h1C00_0010, 32'h0);
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < NL; d++) begin
        checks++;
        if (rvalid_w[d] !== (k == lat_of(d) - 1)) begin
          errors++;
          $display("FAIL wr_rd_timing lat%0d k=%0d: rvalid=%b", lat_of(d), k, rvalid_w[d]);
        end
        if (rvalid_w[d]) begin
          seen[d]++;
          checks++;
          if (rdata_w[d] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_rd_data lat%0d: got %h want deadbeef", lat_of(d), rdata_w[d]);
          end
        end
        checks++;
        if (rdata_w[d] !== exp_rdata[d]) begin
          errors++;
          $display("FAIL wr_rd_hold lat%0d: got %h want %h", lat_of(d), rdata_w[d], exp_rdata[d]);
        end
      end
      idle();
    end
    for (int d = 0; d < NL; d++) begin
      checks++;
      if (seen[d] != 1) begin
        errors++;
        $display("FAIL wr_rd_pulses lat%0d: got %0d want 1", lat_of(d), seen[d]);
      end
    end
  endtask

  task automatic test_partial();
    drive(1'b1, 4'hF, BASE + 32'h14, 32'h1122_3344);
    drive(1'b1, 4'b0101, BASE + 32'h14, 32'hAABB_CCDD);
    drive(1'b1, 4'h0, BASE + 32'h14, 32'h0);
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < NL; d++) begin
        if (k == lat_of(d) - 1) begin
          checks++;
          if (rvalid_w[d] !== 1'b1 || rdata_w[d] !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL partial lat%0d: rvalid=%b rdata=%h want 1/11bb33dd",
                     lat_of(d), rvalid_w[d], rdata_w[d]);
          end
        end
      end
      idle();
    end
  endtask

  task automatic test_back_to_back();
    int k_q [$];
    logic [31:0] d_q [$];
    for (int i = 0; i < 4; i++) drive(1'b1, 4'hF, BASE + 32'h20 + 32'(i * 4), 32'(i + 1));
    for (int k = 0; k < 10; k++) begin
      if (k < 4) drive(1'b1, 4'h0, BASE + 32'h20 + 32'(k * 4), 32'h0);
      else idle();
      if (rvalid_w[1]) begin
        k_q.push_back(k);
        d_q.push_back(rdata_w[1]);
      end
      for (int d = 0; d < NL; d++) begin
        checks++;
        if (rvalid_w[d] !== exp_rvalid[d] || rdata_w[d] !== exp_rdata[d]) begin
          errors++;
          $display("FAIL stream lat%0d k=%0d: rvalid=%b rdata=%h want %b/%h", lat_of(d), k,
                   rvalid_w[d], rdata_w[d], exp_rvalid[d], exp_rdata[d]);
        end
      end
    end
    checks++;
    if (k_q.size() != 4) begin
      errors++;
      $display("FAIL stream_count lat3: got %0d pulses want 4", k_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (k_q[i] != i + 2 || d_q[i] !== 32'(i + 1)) begin
          errors++;
          $display("FAIL stream_order lat3 #%0d: cycle %0d data %h want %0d/%h",
                   i, k_q[i], d_q[i], i + 2, i + 1);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    checks++;
    if (err_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL oor_pre: addr_err=%b want 0", err_w[0]);
    end
    drive(1'b1, 4'h0, 32'h1C00_1000, 32'h0);
    checks++;
    if (err_w[0] !== 1'b1 || rvalid_w[0] !== 1'b1 || rdata_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: err=%b rvalid=%b rdata=%h want 1/1/0",
               err_w[0], rvalid_w[0], rdata_w[0]);
    end
    drive(1'b1, 4'hF, 32'h1C00_1000, 32'h5555_5555);
    drive(1'b1, 4'hF, BASE - 32'd4, 32'h6666_6666);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);
      else idle();
      for (int d = 0; d < NL; d++) begin
        checks++;
        if (rvalid_w[d] !== exp_rvalid[d] || rdata_w[d] !== exp_rdata[d] || err_w[d] !== 1'b1) begin
          errors++;
          $display("FAIL oor_readback lat%0d i=%0d: rvalid=%b rdata=%h err=%b want %b/%h/1",
                   lat_of(d), i, rvalid_w[d], rdata_w[d], err_w[d], exp_rvalid[d], exp_rdata[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h1000 + 32'($urandom_range(0, 4095));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(1'($urandom_range(0, 3) != 0), w, a, $urandom);
      for (int d = 0; d < NL; d++) begin
        checks++;
        if (rvalid_w[d] !== exp_rvalid[d] || rdata_w[d] !== exp_rdata[d] || err_w[d] !== exp_err) begin
          errors++;
          $display("FAIL random lat%0d n=%0d: rvalid=%b rdata=%h err=%b want %b/%h/%b",
                   lat_of(d), n, rvalid_w[d], rdata_w[d], err_w[d],
                   exp_rvalid[d], exp_rdata[d], exp_err);
        end
`ifdef DSRAM_STAT_EN
        checks++;
        if (rd_cnt_w[d] !== 32'(exp_rd_n) || wr_cnt_w[d] !== 32'(exp_wr_n)) begin
          errors++;
          $display("FAIL random_cnt lat%0d: rd=%0d wr=%0d want %0d/%0d",
                   lat_of(d), rd_cnt_w[d], wr_cnt_w[d], exp_rd_n, exp_wr_n);
        end
`endif
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] keep;
    keep = 32'hC0DE_0000 | 32'($urandom_range(0, 65535));
    drive(1'b1, 4'hF, BASE + 32'h0C, keep);
    repeat (5) idle();
    drive(1'b1, 4'h0, BASE + 32'h0C, 32'h0);
    idle();
    resetn = 1'b0;
    repeat (2) idle();
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < NL; d++) begin
        checks++;
        if (rvalid_w[d] !== 1'b0 || err_w[d] !== 1'b0 || rdata_w[d] !== 32'h0) begin
          errors++;
          $display("FAIL midflight lat%0d k=%0d: rvalid=%b err=%b rdata=%h want 0/0/0",
                   lat_of(d), k, rvalid_w[d], err_w[d], rdata_w[d]);
        end
      end
      idle();
    end
    drive(1'b1, 4'h0, BASE + 32'h0C, 32'h0);
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < NL; d++) begin
        if (k == lat_of(d) - 1) begin
          checks++;
          if (rvalid_w[d] !== 1'b1 || rdata_w[d] !== keep) begin
            errors++;
            $display("FAIL persist lat%0d: rvalid=%b rdata=%h want 1/%h",
                     lat_of(d), rvalid_w[d], rdata_w[d], keep);
          end
        end
      end
      idle();
    end
  endtask

`ifdef DSRAM_STAT_EN
  task automatic test_stats();
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
    for (int d = 0; d < NL; d++) begin
      checks++;
      if (rd_cnt_w[d] !== 32'h0 || wr_cnt_w[d] !== 32'h0) begin
        errors++;
        $display("FAIL stat_reset lat%0d: rd=%0d wr=%0d want 0/0", lat_of(d), rd_cnt_w[d], wr_cnt_w[d]);
      end
    end
    drive(1'b1, 4'h0, BASE + 32'h00, 32'h0);
    drive(1'b1, 4'hF, BASE + 32'h04, 32'h1234_5678);
    drive(1'b1, 4'h0, BASE + 32'h08, 32'h0);
    drive(1'b1, 4'b0010, BASE + 32'h08, 32'h0000_AB00);
    drive(1'b1, 4'h0, 32'h1C00_2000, 32'h0);
    drive(1'b1, 4'h0, BASE + 32'h04, 32'h0);
    idle();
    for (int d = 0; d < NL; d++) begin
      checks++;
      if (rd_cnt_w[d] !== 32'd3 || wr_cnt_w[d] !== 32'd2) begin
        errors++;
        $display("FAIL stat_count lat%0d: rd=%0d wr=%0d want 3/2", lat_of(d), rd_cnt_w[d], wr_cnt_w[d]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_partial();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midflight();
`ifdef DSRAM_STAT_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
